// File: rtl/mem_responder.sv
// Bus target for the CPU's 8-bit multiplexed memory bus: serves a loader-filled program ROM and a data RAM.
// Ports: clk/reset (sync, active-low); bus_in/rom_ram/addr_data/bus_valid/bus_wr in; bus_out/out_valid/err out; prog_* ROM loader in.
module mem_responder #(
  parameter int ROM_DEPTH = 32,
  parameter int RAM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bus_in,
  input  logic       rom_ram,
  input  logic       addr_data,
  input  logic       bus_valid,
  input  logic       bus_wr,
  output logic [7:0] bus_out,
  output logic       out_valid,
  output logic       err,
  input  logic       prog_en,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data
);

  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       sel_q, sel_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       ov_q, ov_d;
  logic       err_q, err_d;

  logic [7:0] rom_q [ROM_DEPTH];
  logic [7:0] ram_q [RAM_DEPTH];

  logic       rom_hit, ram_hit, tgt_hit, prog_hit;
  logic [7:0] rd_byte;
  logic       ram_we, rom_we;

  // 9-bit compares so a depth of 256 still works
  assign rom_hit  = {1'b0, addr_q} < 9'(ROM_DEPTH);
  assign ram_hit  = {1'b0, addr_q} < 9'(RAM_DEPTH);
  assign prog_hit = {1'b0, prog_addr} < 9'(ROM_DEPTH);
  assign tgt_hit  = sel_q ? ram_hit : rom_hit;

  // only consumed when tgt_hit, so the truncated index is safe
  assign rd_byte = sel_q ? ram_q[addr_q[RAM_AW-1:0]]
                         : rom_q[addr_q[ROM_AW-1:0]];

  assign rom_we = reset && prog_en && prog_hit;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    bus_out_d = bus_out_q;
    ov_d      = 1'b0;
    err_d     = err_q;
    ram_we    = 1'b0;
    if (prog_en && !prog_hit) err_d = 1'b1;
    if (bus_valid) begin
      if (addr_data) begin
        addr_d  = bus_in;
        sel_d   = rom_ram;
        state_d = ARMED;
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        addr_d = addr_q + 8'd1;
        if (!bus_wr) begin
          ov_d = 1'b1;
          if (tgt_hit) begin
            bus_out_d = rd_byte;
          end else begin
            bus_out_d = 8'h00;
            err_d     = 1'b1;
          end
        end else if (sel_q && ram_hit) begin
          ram_we = reset;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= 8'h00;
      sel_q     <= 1'b0;
      bus_out_q <= 8'h00;
      ov_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      bus_out_q <= bus_out_d;
      ov_q      <= ov_d;
      err_q     <= err_d;
    end
  end

  // array contents survive reset; reset only blocks writes
  always_ff @(posedge clk) begin
    if (rom_we) rom_q[prog_addr[ROM_AW-1:0]] <= prog_data;
    if (ram_we) ram_q[addr_q[RAM_AW-1:0]] <= bus_in;
  end

  assign bus_out   = bus_out_q;
  assign out_valid = ov_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder.
// Each vector drives one cycle of inputs and checks outputs 1 time unit after the edge.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_in;
  logic       rom_ram;
  logic       addr_data;
  logic       bus_valid;
  logic       bus_wr;
  logic [7:0] bus_out;
  logic       out_valid;
  logic       err;
  logic       prog_en;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;

  mem_responder #(.ROM_DEPTH(32), .RAM_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in),
    .rom_ram(rom_ram), .addr_data(addr_data),
    .bus_valid(bus_valid), .bus_wr(bus_wr),
    .bus_out(bus_out), .out_valid(out_valid), .err(err),
    .prog_en(prog_en), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       bv, ad, rr, wr;
    logic [7:0] bi;
    logic       pe;
    logic [7:0] pa, pd;
    logic [7:0] eo;
    logic       ev, ee;
  } vec_t;

  vec_t vt[$];
  int ncmp = 0;
  int nfail = 0;

  task automatic v(input logic r, bv, ad, rr, wr,
                   input logic [7:0] bi, input logic pe,
                   input logic [7:0] pa, pd, eo,
                   input logic ev, ee);
    vec_t t;
    t.r = r; t.bv = bv; t.ad = ad; t.rr = rr; t.wr = wr;
    t.bi = bi; t.pe = pe; t.pa = pa; t.pd = pd;
    t.eo = eo; t.ev = ev; t.ee = ee;
    vt.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] got, exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s step %0d: got %h want %h",
               nm, idx, got, exp);
    end
  endtask

  task automatic step(input vec_t t, input string tag,
                      input int idx);
    reset = t.r; bus_valid = t.bv; addr_data = t.ad;
    rom_ram = t.rr; bus_wr = t.wr; bus_in = t.bi;
    prog_en = t.pe; prog_addr = t.pa; prog_data = t.pd;
    @(posedge clk);
    #1;
    chk({tag, ".bus_out"}, idx, bus_out, t.eo);
    chk({tag, ".out_valid"}, idx, {7'd0, out_valid},
        {7'd0, t.ev});
    chk({tag, ".err"}, idx, {7'd0, err}, {7'd0, t.ee});
  endtask

  initial begin
    reset = 1'b0; bus_valid = 1'b0; addr_data = 1'b0;
    rom_ram = 1'b0; bus_wr = 1'b0; bus_in = 8'h00;
    prog_en = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;

    // r bv ad rr wr bi     pe pa     pd     eo   ev ee
    // reset held 2 cycles with bus and loader active
    v(0, 1, 1, 1, 0, 8'h33, 1, 8'h05, 8'h99, 8'h00, 0, 0);
    v(0, 1, 0, 0, 0, 8'h33, 1, 8'h05, 8'h99, 8'h00, 0, 0);
    v(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    // load ROM[0..3]
    v(1, 0, 0, 0, 0, 8'h00, 1, 8'h00, 8'h11, 8'h00, 0, 0);
    v(1, 0, 0, 0, 0, 8'h00, 1, 8'h01, 8'h22, 8'h00, 0, 0);
    v(1, 0, 0, 0, 0, 8'h00, 1, 8'h02, 8'h33, 8'h00, 0, 0);
    v(1, 0, 0, 0, 0, 8'h00, 1, 8'h03, 8'h44, 8'h00, 0, 0);
    // burst read ROM from 0
    v(1, 1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h11, 1, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h22, 1, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h33, 1, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h44, 1, 0);
    v(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h44, 0, 0);
    // RAM write/read-back at 5
    v(1, 1, 1, 1, 0, 8'h05, 0, 8'h00, 8'h00, 8'h44, 0, 0);
    v(1, 1, 0, 0, 1, 8'hA5, 0, 8'h00, 8'h00, 8'h44, 0, 0);
    v(1, 1, 0, 0, 1, 8'h5A, 0, 8'h00, 8'h00, 8'h44, 0, 0);
    v(1, 1, 1, 1, 0, 8'h05, 0, 8'h00, 8'h00, 8'h44, 0, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'hA5, 1, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h5A, 1, 0);
    // ROM write attempt
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 1, 0, 0, 8'h02, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 0, 0, 1, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 0, 1);
    v(1, 1, 1, 0, 0, 8'h02, 0, 8'h00, 8'h00, 8'h00, 0, 1);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h33, 1, 1);
    // out-of-range and wrap
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 1, 1, 0, 8'h0F, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 0, 0, 1, 8'h77, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 0, 0, 1, 8'h0C, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 1, 1, 0, 8'h0F, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h77, 1, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 1);
    v(1, 1, 1, 1, 0, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 0, 1);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 1);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h0C, 1, 1);
    // data phase in IDLE
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1);
    // loader range: last valid address, then first invalid
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 0, 0, 0, 0, 8'h00, 1, 8'h1F, 8'h6B, 8'h00, 0, 0);
    v(1, 1, 1, 0, 0, 8'h1F, 1, 8'h20, 8'h00, 8'h00, 0, 1);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h6B, 1, 1);
    // same-cycle load and read of ROM[1] returns the old byte
    v(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 1, 0, 0, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 0, 0, 0, 8'h00, 1, 8'h01, 8'hEE, 8'h22, 1, 0);
    v(1, 1, 1, 0, 0, 8'h01, 0, 8'h00, 8'h00, 8'h22, 0, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'hEE, 1, 0);

    foreach (vt[i]) step(vt[i], "tbl", i);
    vt.delete();

    // mid-burst reset: RAM[0]=0x0C, RAM[1] unwritten
    v(1, 1, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'hEE, 0, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h0C, 1, 0);
    v(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1);
    foreach (vt[i]) step(vt[i], "midrst", i);
    vt.delete();

    // reset blocks a simultaneous loader write to ROM[0]
    v(0, 1, 1, 1, 1, 8'h44, 1, 8'h00, 8'h99, 8'h00, 0, 0);
    v(1, 1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);
    v(1, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h11, 1, 0);
    foreach (vt[i]) step(vt[i], "rstload", i);
    vt.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Bus target for the CPU's 8-bit multiplexed memory bus. Sits on the far side of the CPU's `data_out` / `rom_ram` / `addr_data` pins and returns read data into the CPU's `data_in`. It decodes address phases and data phases and serves two internal arrays: a program ROM and a data RAM. The ROM is filled through a separate loader port.

## Interface
Parameters:
- ROM_DEPTH, 32: ROM bytes; valid addresses 0..ROM_DEPTH-1.
- RAM_DEPTH, 16: RAM bytes; valid addresses 0..RAM_DEPTH-1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- bus_in  in  8  byte driven by the CPU (its data_out).
- rom_ram  in  1  target select, sampled only in an address phase: 0 = ROM, 1 = RAM.
- addr_data  in  1  phase type when bus_valid=1: 1 = address phase, 0 = data phase.
- bus_valid  in  1  phase strobe; the inputs above are ignored when 0.
- bus_wr  in  1  data phase is a write (1) or a read (0).
- bus_out  out  8  read data to the CPU (its data_in).
- out_valid  out  1  one-cycle pulse: bus_out holds fresh read data.
- err  out  1  sticky protocol/access error flag.
- prog_en  in  1  ROM loader write strobe.
- prog_addr  in  8  ROM loader address.
- prog_data  in  8  ROM loader data.

## Operation
- FSM states:
  - IDLE: no address latched.
  - ARMED: address latched in `cur_addr[7:0]`, with `cur_sel` recording ROM or RAM.
- Address phase (bus_valid=1, addr_data=1), any state:
  - cur_addr <= bus_in; cur_sel <= rom_ram; state <= ARMED.
  - In ARMED this re-latches the address; no error.
- Read data phase (bus_valid=1, addr_data=0, bus_wr=0) in ARMED:
  - bus_out <= selected array[cur_addr]; out_valid <= 1.
  - cur_addr <= cur_addr+1, modulo 256; 0xFF wraps to 0x00. Stay in ARMED.
  - Out-of-range (cur_addr >= depth of selected array): bus_out <= 0x00, out_valid <= 1, err <= 1, cur_addr still increments.
- Write data phase (bus_wr=1) in ARMED:
  - RAM in range: RAM[cur_addr] <= bus_in; cur_addr increments; no out_valid.
  - ROM target or out-of-range: array unchanged, err <= 1, cur_addr still increments.
- Data phase in IDLE: ignored (no array access, no out_valid); err <= 1.
- bus_wr and rom_ram are don't-care outside the phases in which they are used.
- Loader:
  - prog_en=1 and prog_addr < ROM_DEPTH: ROM[prog_addr] <= prog_data.
  - prog_en=1 and prog_addr out of range: write dropped, err <= 1.
  - The loader is independent of the bus FSM.
  - Same-cycle loader write and bus read of the same ROM address: the read returns the old byte.
- err is cleared only by reset.
- bus_out holds its last value until the next read.

## Timing
- Reset (reset=0 at an edge) sets:
  - state=IDLE, cur_addr=0x00, cur_sel=ROM.
  - bus_out=0x00, out_valid=0, err=0.
  - Array contents are not cleared.
- Reset wins over every simultaneous bus or loader event.
- Reset during ARMED aborts the burst; out_valid is 0 from the first cycle after the reset edge.
- Read latency is 1 cycle: read phase sampled at edge N gives bus_out/out_valid valid after edge N, for the cycle between N and N+1.
- Back-to-back read phases on consecutive cycles stream consecutive bytes with out_valid high continuously.
- A write's effect is visible to a read phase issued on the next cycle.
- Throughput is one phase per cycle; there are no wait states and no backpressure.

## Test plan
- Reset:
  - Stimulus: hold reset=0 for 2 cycles with bus_valid=1 and prog_en=1, then release.
  - Required: bus_out=0x00, out_valid=0, err=0; ROM unchanged.
- Load and burst read:
  - Stimulus: load ROM[0..3]=0x11,0x22,0x33,0x44; address phase 0x00 with rom_ram=0; 4 consecutive read phases.
  - Required: out_valid high 4 cycles, bus_out 0x11,0x22,0x33,0x44, one cycle after each phase; err=0.
- RAM write/read-back:
  - Stimulus: address 0x05 with rom_ram=1; write 0xA5, write 0x5A; address 0x05; read twice.
  - Required: 0xA5 then 0x5A.
- ROM write:
  - Stimulus: address 0x02 with rom_ram=0; write 0xFF; re-address 0x02; read.
  - Required: err=1; read returns the loaded ROM byte, not 0xFF.
- Out-of-range and wrap:
  - Stimulus: address 0x0F with rom_ram=1; 2 reads (RAM_DEPTH=16). Then address 0xFF; 2 reads.
  - Required:
    - First pair: RAM[15] then 0x00 with err=1.
    - Second pair: 0x00 (out of range) then RAM[0] (cur_addr wrapped to 0x00).
- Protocol error and mid-burst reset:
  - Stimulus: data phase straight after reset.
  - Required: err=1, no out_valid.
  - Stimulus: start a RAM read burst; assert reset on the 2nd read edge.
  - Required: out_valid=0 and bus_out=0x00 after that edge; state IDLE.
